// File: rtl/emoji_sprite_ctrl_pkg.sv
// Shared constants and FSM encoding for the emoji sprite controller.
package emoji_sprite_ctrl_pkg;

  localparam int ROM_DIM    = 64;
  localparam int H_ACTIVE_C = 640;
  localparam int V_ACTIVE_C = 480;

  localparam logic [15:0] RGB_BLACK  = 16'h0000;
  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [15:0] RGB_BG     = 16'h001F;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_UPD_X = 2'd1,
    S_UPD_Y = 2'd2
  } state_e;

endpackage

// File: rtl/emoji_sprite_ctrl_if.sv
// Raster, ROM and status signals between the timing side and the sprite controller.
interface emoji_sprite_ctrl_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        video_on;
  logic        frame_tick;
  logic        move_en;
  logic [5:0]  rom_x;
  logic [5:0]  rom_y;
  logic [15:0] rom_rgb;
  logic [15:0] rgb_out;
  logic [10:0] sprite_x;
  logic [10:0] sprite_y;
  logic        edge_hit;

  modport master (
    output hcount, vcount, video_on, frame_tick, move_en, rom_rgb,
    input  rom_x, rom_y, rgb_out, sprite_x, sprite_y, edge_hit
  );

  modport slave (
    input  hcount, vcount, video_on, frame_tick, move_en, rom_rgb,
    output rom_x, rom_y, rgb_out, sprite_x, sprite_y, edge_hit
  );
endinterface

// File: rtl/emoji_sprite_ctrl_axis.sv
// One-axis bounce step: dir_i=0 moves toward MAX, dir_i=1 moves toward 0.
module sprite_axis_bounce #(
  parameter int MAX  = 512,
  parameter int STEP = 2
) (
  input  logic [10:0] pos_i,
  input  logic        dir_i,
  output logic [10:0] pos_o,
  output logic        dir_o,
  output logic        hit_o
);
  localparam logic [11:0] MAX_W  = 12'(MAX);
  localparam logic [11:0] STEP_W = 12'(STEP);

  logic [11:0] pos_w;
  logic [11:0] nxt_up;
  logic [11:0] nxt_dn;

  assign pos_w  = {1'b0, pos_i};
  assign nxt_up = pos_w + STEP_W;
  assign nxt_dn = pos_w - STEP_W;

  always_comb begin
    pos_o = pos_i;
    dir_o = dir_i;
    hit_o = 1'b0;
    if (!dir_i) begin
      if (nxt_up >= MAX_W) begin
        pos_o = MAX_W[10:0];
        dir_o = 1'b1;
        hit_o = 1'b1;
      end else begin
        pos_o = nxt_up[10:0];
      end
    end else begin
      if (pos_w <= STEP_W) begin
        pos_o = 11'd0;
        dir_o = 1'b0;
        hit_o = 1'b1;
      end else begin
        pos_o = nxt_dn[10:0];
      end
    end
  end
endmodule

// File: rtl/emoji_sprite_ctrl.sv
// Maps the raster onto a scaled 64x64 ROM sprite and bounces it once per frame.
module emoji_sprite_ctrl
  import emoji_sprite_ctrl_pkg::*;
#(
  parameter int          H_ACTIVE    = H_ACTIVE_C,
  parameter int          V_ACTIVE    = V_ACTIVE_C,
  parameter int          SCALE_SHIFT = 1,
  parameter int          STEP        = 2,
  parameter int          INIT_X      = 100,
  parameter int          INIT_Y      = 80,
  parameter logic [15:0] BG_COLOR    = RGB_BG,
  parameter logic [15:0] TRANSPARENT = RGB_BLACK
) (
  input logic           clk,
  input logic           rst,
  emoji_sprite_ctrl_if.slave bus
);
  localparam int W     = ROM_DIM << SCALE_SHIFT;
  localparam int MAX_X = H_ACTIVE - W;
  localparam int MAX_Y = V_ACTIVE - W;
  localparam logic [11:0] W_W = 12'(W);

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic        edge_q, edge_d;
  logic        in_box_q, video_on_q;
  logic [15:0] rgb_q, rgb_d;

  // Stage 0: 12-bit compares so sprite_x+W never wraps
  logic [11:0] hc, vc, sx, sy, dx, dy, dx_sh, dy_sh;
  logic        in_box;

  assign hc     = {1'b0, bus.hcount};
  assign vc     = {1'b0, bus.vcount};
  assign sx     = {1'b0, x_q};
  assign sy     = {1'b0, y_q};
  assign dx     = hc - sx;
  assign dy     = vc - sy;
  assign dx_sh  = dx >> SCALE_SHIFT;
  assign dy_sh  = dy >> SCALE_SHIFT;
  assign in_box = bus.video_on && (hc >= sx) && (hc < sx + W_W) &&
                  (vc >= sy) && (vc < sy + W_W);

  assign bus.rom_x = in_box ? dx_sh[5:0] : 6'd0;
  assign bus.rom_y = in_box ? dy_sh[5:0] : 6'd0;

  always_comb begin
    rgb_d = BG_COLOR;
    if (!video_on_q)
      rgb_d = 16'h0000;
    else if (in_box_q && (bus.rom_rgb != TRANSPARENT))
      rgb_d = bus.rom_rgb;
  end

  logic [10:0] ax_pos, ay_pos;
  logic        ax_dir, ay_dir, ax_hit, ay_hit;

  sprite_axis_bounce #(.MAX(MAX_X), .STEP(STEP)) u_axis_x (
    .pos_i(x_q), .dir_i(dir_x_q), .pos_o(ax_pos), .dir_o(ax_dir), .hit_o(ax_hit)
  );

  sprite_axis_bounce #(.MAX(MAX_Y), .STEP(STEP)) u_axis_y (
    .pos_i(y_q), .dir_i(dir_y_q), .pos_o(ay_pos), .dir_o(ay_dir), .hit_o(ay_hit)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    edge_d  = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (bus.frame_tick && bus.move_en) state_d = S_UPD_X;
      end
      S_UPD_X: begin
        x_d     = ax_pos;
        dir_x_d = ax_dir;
        edge_d  = ax_hit;
        state_d = S_UPD_Y;
      end
      S_UPD_Y: begin
        y_d     = ay_pos;
        dir_y_d = ay_dir;
        edge_d  = ay_hit;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT;
      x_q        <= 11'(INIT_X);
      y_q        <= 11'(INIT_Y);
      dir_x_q    <= 1'b0;
      dir_y_q    <= 1'b0;
      edge_q     <= 1'b0;
      in_box_q   <= 1'b0;
      video_on_q <= 1'b0;
      rgb_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      edge_q     <= edge_d;
      in_box_q   <= in_box;
      video_on_q <= bus.video_on;
      rgb_q      <= rgb_d;
    end
  end

  assign bus.rgb_out  = rgb_q;
  assign bus.sprite_x = x_q;
  assign bus.sprite_y = y_q;
  assign bus.edge_hit = edge_q;
endmodule

// File: tb/tb_emoji_sprite_ctrl.sv
// Directed bench for emoji_sprite_ctrl: pixel path, transparency and bounce motion.
module tb_emoji_sprite_ctrl;
  import emoji_sprite_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   frame_no = 0;
  int   edge_cnt = 0;

  emoji_sprite_ctrl_if bus ();

  emoji_sprite_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.edge_hit) edge_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive an address, check ROM coords, supply ROM data a cycle later, check rgb_out.
  task automatic pixel(input string tag, input int h, input int v, input logic von,
                       input logic [15:0] rom, input int ex, input int ey,
                       input logic [15:0] exp_rgb);
    @(negedge clk);
    bus.hcount   = 11'(h);
    bus.vcount   = 11'(v);
    bus.video_on = von;
    #1;
    chk({tag, "_rx"}, 32'(bus.rom_x), 32'(ex));
    chk({tag, "_ry"}, 32'(bus.rom_y), 32'(ey));
    @(negedge clk);
    bus.rom_rgb  = rom;
    bus.video_on = 1'b0;
    @(negedge clk);
    chk({tag, "_rgb"}, 32'(bus.rgb_out), 32'(exp_rgb));
  endtask

  task automatic do_frame(input logic en);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.move_en    = en;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    if (en) frame_no++;
  endtask

  task automatic run_to(input int n);
    while (frame_no < n) do_frame(1'b1);
  endtask

  initial begin
    bus.hcount = '0; bus.vcount = '0; bus.video_on = 1'b0;
    bus.frame_tick = 1'b0; bus.move_en = 1'b0; bus.rom_rgb = '0;
    #23;
    chk("rst_x", 32'(bus.sprite_x), 100);
    chk("rst_y", 32'(bus.sprite_y), 80);
    chk("rst_rgb", 32'(bus.rgb_out), 0);
    chk("rst_edge", 32'(bus.edge_hit), 0);
    @(negedge clk); rst = 1'b0;

    pixel("bg00",  0,   0,   1'b1, RGB_RED,    0,  0,  RGB_BG);
    pixel("tl",    100, 80,  1'b1, RGB_RED,    0,  0,  RGB_RED);
    pixel("br",    227, 207, 1'b1, RGB_YELLOW, 63, 63, RGB_YELLOW);
    pixel("rout",  228, 207, 1'b1, RGB_RED,    0,  0,  RGB_BG);
    pixel("lout",  99,  80,  1'b1, RGB_RED,    0,  0,  RGB_BG);
    pixel("trans", 150, 100, 1'b1, RGB_BLACK,  25, 10, RGB_BG);
    pixel("blank", 100, 80,  1'b0, RGB_RED,    0,  0,  16'h0000);

    repeat (3) do_frame(1'b0);
    chk("noen_x", 32'(bus.sprite_x), 100);
    chk("noen_y", 32'(bus.sprite_y), 80);
    chk("noen_edge", 32'(edge_cnt), 0);

    // frame_tick held into S_UPD_X must not trigger a second update
    @(negedge clk); bus.frame_tick = 1'b1; bus.move_en = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    frame_no = 1;
    chk("dbl_x", 32'(bus.sprite_x), 102);
    chk("dbl_y", 32'(bus.sprite_y), 82);

    run_to(205);
    chk("f205_x", 32'(bus.sprite_x), 510);
    chk("f205_y", 32'(bus.sprite_y), 214);
    chk("f205_edges", 32'(edge_cnt), 1);
    run_to(206);
    chk("f206_x", 32'(bus.sprite_x), 512);
    chk("f206_edges", 32'(edge_cnt), 2);
    run_to(207);
    chk("f207_x", 32'(bus.sprite_x), 510);
    run_to(461);
    chk("f461_x", 32'(bus.sprite_x), 2);
    chk("f461_y", 32'(bus.sprite_y), 298);
    run_to(462);
    chk("f462_x", 32'(bus.sprite_x), 0);
    chk("f462_y", 32'(bus.sprite_y), 300);
    chk("f462_edges", 32'(edge_cnt), 4);
    run_to(463);
    chk("f463_x", 32'(bus.sprite_x), 2);

    // frame 718 flips x; reset lands in S_UPD_Y while edge_hit is high
    run_to(717);
    chk("f717_x", 32'(bus.sprite_x), 510);
    @(negedge clk); bus.frame_tick = 1'b1;
    @(negedge clk); bus.frame_tick = 1'b0;
    @(negedge clk);
    chk("mid_edge", 32'(bus.edge_hit), 1);
    chk("mid_x", 32'(bus.sprite_x), 512);
    rst = 1'b1;
    #1;
    chk("rstmid_x", 32'(bus.sprite_x), 100);
    chk("rstmid_y", 32'(bus.sprite_y), 80);
    chk("rstmid_edge", 32'(bus.edge_hit), 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_y", 32'(bus.sprite_y), 80);
    do_frame(1'b1);
    chk("post_rst_fx", 32'(bus.sprite_x), 102);
    chk("post_rst_fy", 32'(bus.sprite_y), 82);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/emoji_sprite_ctrl.md
Name: emoji_sprite_ctrl

Overview:
Sequences the 64x64 emoji ROM onto the 640x480 VGA raster as a movable, scaled, bouncing sprite. Per pixel, it maps raster counters to ROM pixel_x/pixel_y, aligns the ROM's 1-cycle registered output, and muxes sprite against background with black treated as transparent. Once per frame, after frame_tick, a small FSM updates the sprite position and bounces it off the screen edges. It sits between the VGA timing generator and the RGB565 output stage.

Parameters:
H_ACTIVE, 640, visible width in pixels
V_ACTIVE, 480, visible height in pixels
SCALE_SHIFT, 1, on-screen size W = 64<<SCALE_SHIFT (default 128)
STEP, 2, pixels moved per axis per frame
INIT_X, 100, reset sprite left edge
INIT_Y, 80, reset sprite top edge
BG_COLOR, 16'h001F, background RGB565
TRANSPARENT, 16'h0000, ROM colour replaced by background

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
hcount  in  11  raster column
vcount  in  11  raster row
video_on  in  1  high in active area
frame_tick  in  1  one-cycle pulse at start of vblank
move_en  in  1  enables per-frame motion
rom_x  out  6  ROM pixel_x, combinational
rom_y  out  6  ROM pixel_y, combinational
rom_rgb  in  16  ROM rgb_data, valid 1 cycle after rom_x/rom_y
rgb_out  out  16  registered pixel colour
sprite_x  out  11  current left edge, registered
sprite_y  out  11  current top edge, registered
edge_hit  out  1  one-cycle pulse on any bounce

Behaviour:
- Reset (async, rst=1): sprite_x=INIT_X, sprite_y=INIT_Y, dir_x=dir_y=+ (increasing), state=S_WAIT, rgb_out=0, edge_hit=0, pipeline valid flags=0.
- Stage 0 (combinational): in_box = video_on & hcount in [sprite_x, sprite_x+W) & vcount in [sprite_y, sprite_y+W). If in_box, rom_x=(hcount-sprite_x)>>SCALE_SHIFT and rom_y=(vcount-sprite_y)>>SCALE_SHIFT, truncated to 6 bits. Otherwise both are 0. Compares use 12-bit unsigned arithmetic with no overflow.
- Stage 1: in_box_d and video_on_d are registered one cycle to align with rom_rgb.
- Stage 2, rgb_out register:
  - !video_on_d gives 0.
  - in_box_d & rom_rgb!=TRANSPARENT gives rom_rgb.
  - Otherwise BG_COLOR.
  - Total latency from hcount/vcount to rgb_out is 2 clocks; the timing generator delays sync by 2.
- FSM states:
  - S_WAIT: on frame_tick & move_en, go to S_UPD_X. frame_tick with move_en=0 is ignored.
  - S_UPD_X: apply the axis rule to x, then go to S_UPD_Y.
  - S_UPD_Y: apply the axis rule to y, then go to S_WAIT.
- Axis rule, with MAX_X=H_ACTIVE-W and MAX_Y=V_ACTIVE-W:
  - dir + : nxt=pos+STEP. If nxt>=MAX, pos=MAX, dir flips to -, and edge_hit pulses. Otherwise pos=nxt.
  - dir - : if pos<=STEP, pos=0, dir flips to +, and edge_hit pulses. Otherwise pos=pos-STEP.
  - edge_hit is registered. It is high for exactly the cycle after the flipping update state, even if both axes flip in the same frame (two pulses, one per axis).
- frame_tick arriving in S_UPD_X/S_UPD_Y is ignored; no queuing.
- Position changes only in the update states, which occur in vblank, so there is no mid-frame tearing.
- move_en deasserting mid-update does not abort the sequence; the update completes.
- Reset asserted mid-update returns all state to the reset values immediately.

Decomposition:
- Shared package holds:
  - the RGB565 colour constants (black/red/yellow/BG);
  - the 64-pixel ROM dimension;
  - the 640x480 active constants;
  - the FSM state encoding (S_WAIT=0, S_UPD_X=1, S_UPD_Y=2).
- One natural sub-module: sprite_axis_bounce. It takes pos, dir, MAX and STEP and returns next pos, next dir and a hit flag. It is instantiated (or called) once per axis.

Test Plan:
- Reset release: expect sprite_x=100, sprite_y=80 and rgb_out=0. With video_on=1 at hcount=0, vcount=0, expect rgb_out=16'h001F two clocks later.
- hcount=100, vcount=80, rom_rgb=16'hF800 driven 1 cycle later: expect rom_x=0, rom_y=0, and rgb_out=16'hF800 two clocks after the address. At hcount=227, vcount=207, expect rom_x=63, rom_y=63. At hcount=228, expect rom_x=0 and BG.
- In-box pixel with rom_rgb=16'h0000: expect rgb_out=16'h001F (transparent).
- Force sprite_x=510, dir +, then frame_tick: expect sprite_x=512, dir -, one edge_hit pulse. Next frame_tick: expect sprite_x=510. At the left edge, sprite_x=1, dir -: expect 0, dir +, edge_hit.
- move_en=0 over 3 frame_ticks: expect position unchanged. frame_tick pulsed in S_UPD_X: expect a single step only.
- Assert rst during S_UPD_Y: expect immediate INIT_X/INIT_Y, S_WAIT, and edge_hit=0.
